clk_sel_ctrl: RTL and testbench

Clock-select sequencer that sits directly upstream of `clk_switch` and is the only driver of its `selb` input. It accepts select requests over a valid/ready handshake, changes `selb` as a clean registered level, and blocks further requests for a programmable settle window so `clk_switch` can finish its internal handover before another change arrives. It reports completion with a one-cycle `done` pulse and keeps a saturating count of real switches.

---
 rtl/clk_sel_ctrl.sv | 91 +++++++++
 tb/tb_clk_sel_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/clk_sel_ctrl.sv
// Clock-select sequencer feeding clk_switch: accepts select requests, drives a
// registered selb level, and holds off new requests for a settle window.
module clk_sel_ctrl #(
    parameter int SETTLE_CYC = 16,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic             req_sel,
    output logic             req_ready,
    output logic             selb,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] switch_cnt
);

    localparam int SCW = $clog2(SETTLE_CYC + 1);
    localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t         state;
    logic [SCW-1:0] settle_cnt;
    logic           accept;

    // req_ready is a registered flag that is high only in IDLE, so accepting
    // never depends combinationally on req_valid.
    assign accept = req_valid && req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            selb       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            req_ready  <= 1'b1;
            switch_cnt <= '0;
            settle_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (accept) begin
                        req_ready <= 1'b0;
                        if (req_sel != selb) begin
                            selb       <= req_sel;
                            settle_cnt <= '0;
                            busy       <= 1'b1;
                            state      <= SETTLE;
                            if (switch_cnt != {CNT_W{1'b1}}) begin
                                switch_cnt <= switch_cnt + 1'b1;
                            end
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end

                // selb is held steady here while clk_switch completes its handover
                SETTLE: begin
                    settle_cnt <= settle_cnt + 1'b1;
                    if (settle_cnt == SETTLE_LAST) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end

                DONE: begin
                    done      <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end

                default: begin
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// Randomized self-checking bench for clk_sel_ctrl; two instances (default and a
// short-settle, 2-bit-counter variant) are compared against a timing model.
module tb_clk_sel_ctrl;

    localparam int S0 = 16;
    localparam int S1 = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rv0 = 1'b0, rs0 = 1'b0, rr0, sb0, bz0, dn0;
    logic [7:0] sc0;
    logic       rv1 = 1'b0, rs1 = 1'b0, rr1, sb1, bz1, dn1;
    logic [1:0] sc1;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Model state is expressed as absolute edge numbers derived from the timing rules
    int settle[2] = '{S0, S1};
    int cmax[2]   = '{255, 3};
    bit m_selb[2];
    int m_cnt[2];
    int m_ready_from[2];
    int m_busy_from[2];
    int m_busy_to[2];
    int m_done_edge[2];

    clk_sel_ctrl #(.SETTLE_CYC(S0), .CNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv0), .req_sel(rs0),
        .req_ready(rr0), .selb(sb0), .busy(bz0), .done(dn0), .switch_cnt(sc0)
    );

    clk_sel_ctrl #(.SETTLE_CYC(S1), .CNT_W(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(rv1), .req_sel(rs1),
        .req_ready(rr1), .selb(sb1), .busy(bz1), .done(dn1), .switch_cnt(sc1)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic void modelReset();
        for (int d = 0; d < 2; d++) begin
            m_selb[d]       = 1'b0;
            m_cnt[d]        = 0;
            m_ready_from[d] = 0;
            m_busy_from[d]  = -1000;
            m_busy_to[d]    = -1000;
            m_done_edge[d]  = -1000;
        end
    endfunction

    function automatic void modelStep(input int d, input bit v, input bit s);
        if (v && cyc >= m_ready_from[d]) begin
            if (s != m_selb[d]) begin
                m_selb[d] = s;
                if (m_cnt[d] < cmax[d]) m_cnt[d]++;
                m_busy_from[d]  = cyc;
                m_busy_to[d]    = cyc + settle[d];
                m_done_edge[d]  = cyc + settle[d];
                m_ready_from[d] = cyc + settle[d] + 2;
            end else begin
                m_done_edge[d]  = cyc;
                m_ready_from[d] = cyc + 2;
            end
        end
    endfunction

    task automatic compareAll();
        checkOutput("dut0 req_ready", 32'(rr0), 32'(cyc + 1 >= m_ready_from[0]));
        checkOutput("dut0 selb", 32'(sb0), 32'(m_selb[0]));
        checkOutput("dut0 busy", 32'(bz0), 32'(cyc >= m_busy_from[0] && cyc < m_busy_to[0]));
        checkOutput("dut0 done", 32'(dn0), 32'(cyc == m_done_edge[0]));
        checkOutput("dut0 switch_cnt", 32'(sc0), 32'(m_cnt[0]));
        checkOutput("dut1 req_ready", 32'(rr1), 32'(cyc + 1 >= m_ready_from[1]));
        checkOutput("dut1 selb", 32'(sb1), 32'(m_selb[1]));
        checkOutput("dut1 busy", 32'(bz1), 32'(cyc >= m_busy_from[1] && cyc < m_busy_to[1]));
        checkOutput("dut1 done", 32'(dn1), 32'(cyc == m_done_edge[1]));
        checkOutput("dut1 switch_cnt", 32'(sc1), 32'(m_cnt[1]));
    endtask

    // Called at a negedge: drive inputs, clock once, advance model, compare
    task automatic applyStimulus(input bit v0, input bit s0, input bit v1, input bit s1);
        rv0 = v0; rs0 = s0; rv1 = v1; rs1 = s1;
        @(posedge clk);
        cyc++;
        if (rst_n) begin
            modelStep(0, v0, s0);
            modelStep(1, v1, s1);
        end
        @(negedge clk);
        compareAll();
    endtask

    // Asynchronous reset check: outputs must clear before any clock edge
    task automatic doReset();
        rv0 = 1'b0; rv1 = 1'b0;
        rst_n = 1'b0;
        modelReset();
        #1;
        compareAll();
        @(negedge clk);
        @(negedge clk);
        compareAll();
        rst_n = 1'b1;
    endtask

    initial begin
        modelReset();
        @(negedge clk);
        @(negedge clk);
        compareAll();
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        // Back-to-back toggling with the request held; dut1 exercises counter saturation
        for (int i = 0; i < 40; i++) applyStimulus(1'b1, !m_selb[0], 1'b1, !m_selb[1]);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        if (!m_selb[0]) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
            for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(1'b1, 1'b1, 1'b1, m_selb[1]);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(199) == 0) doReset();
            applyStimulus(1'($urandom_range(1)), 1'($urandom_range(1)),
                          1'($urandom_range(1)), 1'($urandom_range(1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
